// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU decode constants for the P7 pipeline.
//   mdu_op_e      : MDUOp encoding, also driven by the instruction controller.
//   mdu_state_e   : IDLE/RUN view of the MDU cycle counter.
//   *_CYCLES_DEF  : default Busy lengths for multiply and divide.
// Code 7 (MDU_MADD) is only acted on when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_MADD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit holding architectural HI/LO.
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   MDUOp      : operation code (mdu_pkg::mdu_op_e)
//   MDU_start  : launch a multi-cycle op this cycle
//   A, B       : forwarded rs / rt operands
//   Req        : flush of the instruction currently in E
//   Busy       : multi-cycle op in flight
//   HI, LO     : architectural HI / LO
// Build option: define MDU_MADD_EN to enable code 7 as MADD
// ({HI,LO} += signed A * signed B); otherwise code 7 is a NOP.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDUOp,
  input  logic        MDU_start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hi_q, hi_n, lo_q, lo_n;
  logic [31:0]      tmp_hi, tmp_hi_n, tmp_lo, tmp_lo_n;
  // Cleared for divide-by-zero so completion leaves HI/LO untouched.
  logic             res_wr, res_wr_n;
  mdu_state_e       state;
  mdu_op_e          op;

  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        div_zero, div_ovf;
`ifdef MDU_MADD_EN
  logic [63:0] madd_sum;
`endif

  // Datapath: all candidate results formed from A/B, selected at start.
  always_comb begin
    prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u   = {32'b0, A} * {32'b0, B};
    div_zero = (B == '0);
    // INT_MIN / -1 wraps to INT_MIN with zero remainder; handled explicitly
    // rather than relying on the tool's signed-overflow behaviour.
    div_ovf  = (A == 32'h8000_0000) && (B == '1);
    quo_s    = '0;
    rem_s    = '0;
    quo_u    = '0;
    rem_u    = '0;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = '0;
    end else if (!div_zero) begin
      quo_s = $signed(A) / $signed(B);
      rem_s = $signed(A) % $signed(B);
    end
    if (!div_zero) begin
      quo_u = A / B;
      rem_u = A % B;
    end
`ifdef MDU_MADD_EN
    madd_sum = {hi_q, lo_q} + prod_s;
`endif
  end

  always_comb begin
    state = (cnt != '0) ? ST_RUN : ST_IDLE;
    op    = mdu_op_e'(MDUOp);
  end

  always_comb begin
    cnt_n    = cnt;
    hi_n     = hi_q;
    lo_n     = lo_q;
    tmp_hi_n = tmp_hi;
    tmp_lo_n = tmp_lo;
    res_wr_n = res_wr;
    case (state)
      ST_IDLE: begin
        if (!Req) begin
          case (op)
            MDU_MULT: if (MDU_start) begin
              cnt_n    = CNT_W'(MULT_CYCLES);
              res_wr_n = 1'b1;
              {tmp_hi_n, tmp_lo_n} = prod_s;
            end
            MDU_MULTU: if (MDU_start) begin
              cnt_n    = CNT_W'(MULT_CYCLES);
              res_wr_n = 1'b1;
              {tmp_hi_n, tmp_lo_n} = prod_u;
            end
            MDU_DIV: if (MDU_start) begin
              cnt_n    = CNT_W'(DIV_CYCLES);
              res_wr_n = !div_zero;
              tmp_hi_n = rem_s;
              tmp_lo_n = quo_s;
            end
            MDU_DIVU: if (MDU_start) begin
              cnt_n    = CNT_W'(DIV_CYCLES);
              res_wr_n = !div_zero;
              tmp_hi_n = rem_u;
              tmp_lo_n = quo_u;
            end
`ifdef MDU_MADD_EN
            MDU_MADD: if (MDU_start) begin
              cnt_n    = CNT_W'(MULT_CYCLES);
              res_wr_n = 1'b1;
              {tmp_hi_n, tmp_lo_n} = madd_sum;
            end
`endif
            MDU_MTHI: hi_n = A;
            MDU_MTLO: lo_n = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Starts and moves arriving here are protocol violations and dropped.
        cnt_n = cnt - CNT_W'(1);
        if ((cnt == CNT_W'(1)) && res_wr) begin
          hi_n = tmp_hi;
          lo_n = tmp_lo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      tmp_hi <= '0;
      tmp_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      tmp_hi <= tmp_hi_n;
      tmp_lo <= tmp_lo_n;
      res_wr <= res_wr_n;
    end
  end

  always_comb begin
    Busy = (state == ST_RUN);
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. Stimulus pushes cycle-stamped expected
// Busy/HI/LO records; a negedge monitor pops and compares them.
// Covers the MADD case under MDU_MADD_EN, or the code-7-is-NOP case otherwise.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  MDUOp;
  logic        MDU_start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .MDU_start(MDU_start),
    .A(A), .B(B), .Req(Req), .Busy(Busy), .HI(HI), .LO(LO)
  );

  typedef struct {
    int unsigned cyc;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } rec_t;

  rec_t        sb[$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every record whose cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      rec_t r;
      r = sb.pop_front();
      total = total + 1;
      if (r.cyc != cyc) begin
        bad = bad + 1;
        $display("FAIL %s: record for cycle %0d checked late at cycle %0d", r.name, r.cyc, cyc);
      end else if (Busy !== r.busy || HI !== r.hi || LO !== r.lo) begin
        bad = bad + 1;
        $display("FAIL %s @%0d: got busy=%b hi=%h lo=%h, want busy=%b hi=%h lo=%h",
                 r.name, cyc, Busy, HI, LO, r.busy, r.hi, r.lo);
      end
    end
  end

  // The hazard unit must never present a start while Busy.
  always @(posedge clk) begin
    if (reset && MDU_start && Busy) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL protocol: MDU_start=%b while Busy=%b", MDU_start, Busy);
    end
  end

  task automatic push(input int unsigned c, input logic bsy, input logic [31:0] h,
                      input logic [31:0] l, input string nm);
    rec_t r;
    r.cyc = c; r.busy = bsy; r.hi = h; r.lo = l; r.name = nm;
    sb.push_back(r);
  endtask

  // Busy for n cycles with old HI/LO, then new HI/LO in the cycle Busy drops.
  task automatic expect_run(input int unsigned e0, input int unsigned n,
                            input logic [31:0] oh, input logic [31:0] ol,
                            input logic [31:0] nh, input logic [31:0] nl, input string nm);
    for (int unsigned i = 0; i < n; i++) push(e0 + i, 1'b1, oh, ol, nm);
    push(e0 + n, 1'b0, nh, nl, nm);
  endtask

  task automatic expect_idle(input int unsigned e0, input int unsigned n,
                             input logic [31:0] h, input logic [31:0] l, input string nm);
    for (int unsigned i = 0; i <= n; i++) push(e0 + i, 1'b0, h, l, nm);
  endtask

  // Drive one op for one cycle; e0 is the edge that sampled it.
  task automatic start_op(input logic [2:0] op, input logic st, input logic [31:0] a,
                          input logic [31:0] b, input logic rq, output int unsigned e0);
    @(negedge clk);
    MDUOp = op; MDU_start = st; A = a; B = b; Req = rq;
    @(posedge clk);
    #1;
    e0 = cyc;
    MDUOp = MDU_NOP; MDU_start = 1'b0; A = '0; B = '0; Req = 1'b0;
  endtask

  initial begin
    int unsigned e0;
    reset = 1'b0; MDUOp = MDU_NOP; MDU_start = 1'b0; A = '0; B = '0; Req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, 1'b0, 32'h0, 32'h0, "reset");
    @(negedge clk);
    reset = 1'b1;

    start_op(MDU_MULT, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, e0);
    expect_run(e0, 5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    repeat (5) @(posedge clk);

    start_op(MDU_MULTU, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, e0);
    expect_run(e0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE, "multu");
    repeat (5) @(posedge clk);

    start_op(MDU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, e0);
    expect_run(e0, 10, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    repeat (10) @(posedge clk);

    start_op(MDU_DIVU, 1'b1, 32'd7, 32'd2, 1'b0, e0);
    expect_run(e0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h1, 32'h3, "divu");
    repeat (10) @(posedge clk);

    start_op(MDU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, e0);
    expect_run(e0, 10, 32'h1, 32'h3, 32'h0, 32'h8000_0000, "div_ovf");
    repeat (10) @(posedge clk);

    start_op(MDU_MTHI, 1'b0, 32'h1234, 32'h0, 1'b0, e0);
    expect_idle(e0, 0, 32'h1234, 32'h8000_0000, "mthi");
    start_op(MDU_MTLO, 1'b0, 32'h5678, 32'h0, 1'b0, e0);
    expect_idle(e0, 0, 32'h1234, 32'h5678, "mtlo");

    start_op(MDU_DIV, 1'b1, 32'd5, 32'd0, 1'b0, e0);
    expect_run(e0, 10, 32'h1234, 32'h5678, 32'h1234, 32'h5678, "div0");
    repeat (10) @(posedge clk);

    start_op(MDU_MULT, 1'b1, 32'd3, 32'd3, 1'b1, e0);
    expect_idle(e0, 6, 32'h1234, 32'h5678, "req_mult");
    repeat (6) @(posedge clk);

    start_op(MDU_MTLO, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, e0);
    expect_idle(e0, 2, 32'h1234, 32'h5678, "req_mtlo");
    repeat (2) @(posedge clk);

    start_op(MDU_DIVU, 1'b1, 32'd100, 32'd7, 1'b0, e0);
    expect_run(e0, 10, 32'h1234, 32'h5678, 32'h2, 32'hE, "divu_req");
    repeat (2) @(posedge clk);
    @(negedge clk);
    Req = 1'b1;
    @(posedge clk);
    #1;
    Req = 1'b0;
    repeat (7) @(posedge clk);

    start_op(MDU_MULT, 1'b1, 32'd5, 32'd6, 1'b0, e0);
    for (int unsigned i = 0; i < 4; i++) push(e0 + i, 1'b1, 32'h2, 32'hE, "rst_mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    expect_idle(e0 + 4, 4, 32'h0, 32'h0, "rst_mid");
    repeat (4) @(posedge clk);

    start_op(MDU_MTHI, 1'b0, 32'h0, 32'h0, 1'b0, e0);
    expect_idle(e0, 0, 32'h0, 32'h0, "madd_mthi");
    start_op(MDU_MTLO, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, e0);
    expect_idle(e0, 0, 32'h0, 32'hFFFF_FFFF, "madd_mtlo");
    start_op(MDU_MADD, 1'b1, 32'd1, 32'd1, 1'b0, e0);
`ifdef MDU_MADD_EN
    expect_run(e0, 5, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, "madd");
    repeat (5) @(posedge clk);
`else
    expect_idle(e0, 6, 32'h0, 32'hFFFF_FFFF, "code7_nop");
    repeat (6) @(posedge clk);
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain: %0d records left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the E stage of the P7 pipeline. Consumes the `MDUOp`/`MDU_start` decode produced by the instruction controller and the forwarded rs/rt operands. Runs multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO, holds the architectural HI/LO registers, and exports `Busy` to the hazard unit. Exports HI/LO to the E-stage result mux for MFHI/MFLO.

## Interface
- `MULT_CYCLES`, 5: cycles `Busy` stays high after a MULT/MULTU/MADD start.
- `DIV_CYCLES`, 10: cycles `Busy` stays high after a DIV/DIVU start.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `MDUOp` input 3: operation code (package encoding).
- `MDU_start` input 1: launch a multi-cycle op this cycle.
- `A` input 32: forwarded rs value.
- `B` input 32: forwarded rt value.
- `Req` input 1: exception/interrupt flush of the instruction currently in E.
- `Busy` output 1: a multi-cycle op is in flight.
- `HI` output 32: architectural HI.
- `LO` output 32: architectural LO.

## Operation
- Op codes:
  - NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7.
- States: IDLE (`cnt`==0) and RUN (`cnt`!=0). `Busy` = (`cnt`!=0).
- Start accepted only when all hold:
  - `MDU_start`=1.
  - `Req`=0.
  - IDLE.
  - `MDUOp` is in {MULT, MULTU, DIV, DIVU, MADD}.
- On an accepted start:
  - Compute the result from `A`/`B` into internal `tmp_hi`/`tmp_lo`.
  - Load `cnt` with `MULT_CYCLES` (MULT/MULTU/MADD) or `DIV_CYCLES` (DIV/DIVU).
- Result arithmetic:
  - MULT: signed 64-bit product; `tmp_hi`=[63:32], `tmp_lo`=[31:0].
  - MULTU: unsigned 64-bit product; same split.
  - DIV: signed; quotient → `tmp_lo`, remainder → `tmp_hi`. Quotient truncates toward zero; remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned; same result placement as DIV.
  - B==0 for DIV/DIVU: `Busy` still runs the full `DIV_CYCLES`; HI/LO are left unchanged at completion.
- RUN: `cnt` decrements each cycle. On the edge where `cnt` goes 1→0, HI<=`tmp_hi` and LO<=`tmp_lo`.
- MTHI / MTLO:
  - Write HI / LO from `A` on the next edge when `Req`=0 and IDLE.
  - They do not assert `Busy`.
- `Req`=1:
  - Suppresses any start or MTHI/MTLO in that cycle.
  - An op already in RUN is not cancelled; it completes normally, because its instruction has already left E.
- Start or MTHI/MTLO while RUN: ignored. The hazard unit stalls E on `Busy`|`MDU_start`, so this is a protocol violation the bench flags.
- Reset: `cnt`=0, HI=0, LO=0, `tmp_hi`=`tmp_lo`=0, `Busy`=0. Takes precedence over everything, including mid-RUN.

## Timing
- Start sampled at edge e0.
- `Busy`=1 during the N cycles after e0 (N=`MULT_CYCLES` or `DIV_CYCLES`).
- HI/LO are updated at edge eN and visible in the same cycle `Busy` drops.
- An MFHI/MFLO stalled behind `Busy` reads the new value in the first cycle `Busy`=0.
- MTHI/MTLO latency: 1 edge.
- HI/LO/`Busy` are registered outputs only; no combinational input→output paths.
- Back-to-back: a new start is accepted in the first cycle `Busy`=0.

## Configuration
- `MDU_MADD_EN` defined:
  - Code 7 is MADD: {HI,LO} + signed(`A`)×signed(`B`), modulo 2^64.
  - The sum is computed at start from the current HI/LO, which are stable because the unit is IDLE.
  - Completion follows the `MULT_CYCLES` timing.
- `MDU_MADD_EN` undefined:
  - Code 7 is treated as NOP: no start, `Busy` stays 0, HI/LO unchanged.

## Structure
- Shared constants package (alongside the existing decode constants) holds:
  - `MDU_NOP`…`MDU_MADD` codes.
  - Default `MULT_CYCLES`/`DIV_CYCLES`.
  - The controller uses the same `MDU_*` codes.
- Single module, no sub-module: the datapath is one product/quotient expression set plus a counter.

## Test plan
- Reset then MULT A=0xFFFFFFFF, B=2:
  - `Busy` is high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands gives HI=1, LO=0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9), B=2:
  - `Busy` is high for exactly 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 gives LO=3, HI=1.
- DIV by zero after MTHI 0x1234 / MTLO 0x5678:
  - `Busy` is high 10 cycles.
  - HI/LO remain 0x1234/0x5678.
- `Req`=1 coincident with MULT start or MTLO: `Busy` stays 0 and HI/LO are unchanged.
- `Req`=1 during cycle 3 of a running DIVU: the op still completes and HI/LO are updated.
- Reset (`reset`=0) in cycle 4 of a MULT: next cycle `Busy`=0, HI=LO=0, and no later write.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADD 1×1 → HI=1, LO=0.
